timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
- Controller and sequencer for a free-running WIDTH-bit counter.
- Adds a prescaler, a compare/terminal value, one-shot and periodic modes, start/stop/pause control, and single-cycle match/done event pulses.
- Sits between the system control logic and the tick counter. Used to derive slow periodic events (e.g. 1 Hz from the 40 kHz system clock) and timed one-shot delays.

Parameters:
- WIDTH, 16, width of the main count and the compare value.
- PRE_WIDTH, 16, width of the prescaler count and the prescale value.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; latches the configuration and begins counting (honoured in IDLE only).
- stop  in  1  pulse; aborts the run and returns to IDLE.
- pause  in  1  level; freezes all counters while high during a run.
- mode  in  1  0 = one-shot, 1 = periodic; sampled on start.
- prescale  in  PRE_WIDTH  the main count advances every prescale+1 clocks; sampled on start.
- compare  in  WIDTH  terminal count; sampled on start.
- cnt  out  WIDTH  current main count.
- busy  out  1  high in RUN or PAUSE.
- paused  out  1  high in PAUSE.
- match  out  1  one-cycle pulse on each terminal tick.
- done  out  1  one-cycle pulse when a one-shot run completes.

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - State goes to IDLE.
  - cnt, internal prescale count, shadow mode/prescale/compare, match and done all become 0.
  - busy and paused are 0.
  - rst mid-run aborts immediately; no match or done is emitted.
- States are IDLE, RUN and PAUSE.
- Outputs are registered: busy = (state != IDLE), paused = (state == PAUSE).
- IDLE:
  - start (and not stop) captures mode/prescale/compare into shadow registers.
  - cnt <= 0, prescale count <= 0, next state RUN.
  - stop in the same cycle as start wins: the block stays in IDLE.
  - In IDLE, cnt holds its last value.
- RUN:
  - The prescale count increments every clock.
  - A tick occurs when the prescale count == prescale_q: the prescale count <= 0 and the main count advances.
  - On a tick with cnt != compare_q: cnt <= cnt + 1.
  - On a tick with cnt == compare_q (terminal tick): match <= 1 for exactly one cycle, then:
    - periodic: cnt <= 0, stay in RUN.
    - one-shot: cnt holds compare_q, done <= 1 for one cycle, next state IDLE (busy falls on the same edge).
- Period:
  - Terminal ticks are (compare_q+1)*(prescale_q+1) clocks apart.
  - The first terminal tick is that many clocks after entering RUN.
- PAUSE:
  - pause high in RUN moves to PAUSE on the next edge.
  - The prescale count and cnt are frozen, and no tick occurs on that edge.
  - pause low returns to RUN, and counting continues from the frozen values.
- Priority per edge: rst > stop > pause > tick.
  - stop in RUN/PAUSE: next state IDLE, cnt <= 0, prescale count <= 0, no match/done.
  - start in RUN/PAUSE is ignored; the shadow configuration is unchanged.
- Boundary cases:
  - compare = 0: every tick is terminal; periodic gives match every prescale+1 clocks.
  - prescale = 0: a tick every clock.
  - compare = all-ones: no overflow is possible, because cnt never exceeds compare_q.
- Inputs mode/prescale/compare may change freely during a run; only the shadow copies are used.

Decomposition:
- Shared header timer_defs.vh holds:
  - state encodings ST_IDLE, ST_RUN, ST_PAUSE (2-bit).
  - mode constants MODE_ONESHOT = 0, MODE_PERIODIC = 1.
- One sub-module, prescaler: PRE_WIDTH counter with clear/enable/limit inputs and a tick output.
- The FSM, shadow registers and main count stay in timer_ctrl.

Test Plan:
- Periodic, prescale=0, compare=3, start -> cnt 0,1,2,3,0,1,… one step per clock; match high on every 4th clock; done never; busy stays 1.
- One-shot, prescale=1, compare=5 -> match and done both pulse exactly 12 clocks after entering RUN; cnt holds 5; busy drops with done; a second start restarts from 0.
- Periodic, prescale=39999, compare=0 -> match every 40000 clocks (1 s at 40 kHz); check 3 consecutive intervals.
- Pause: periodic, prescale=0, compare=9, pause high for 7 clocks at cnt=4 -> paused=1, cnt frozen at 4; after release, the terminal match is delayed by exactly 7 clocks.
- Stop and start conflicts: stop at cnt=6 -> IDLE next edge, cnt=0, no match/done; start+stop together in IDLE -> stays IDLE; start during RUN with a new compare -> ignored, old period kept.
- Reset mid-run: rst at cnt=3 during a one-shot -> all outputs 0 next edge, no done; counting resumes only on a new start.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// timer_ctrl_pkg
// Shared definitions for the timer controller and its prescaler:
//   - state_e       : controller state encoding (IDLE / RUN / PAUSE, 2 bits)
//   - MODE_*        : run-mode constants sampled on start
//   - in_run_phase  : true for any state that belongs to an active run
// -----------------------------------------------------------------------------
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // RUN and PAUSE both count as "busy"; only IDLE is outside a run.
  function automatic logic in_run_phase(input state_e s);
    return (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/timer_ctrl_prescaler.sv
// -----------------------------------------------------------------------------
// timer_ctrl_prescaler
// Divides the system clock: while enabled, an internal counter runs
// 0,1,...,limit and wraps. tick is high in the cycle where the counter sits
// at limit and the counter is enabled, so one tick is produced every limit+1
// enabled clocks.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset (counter to 0)
//   clr    in   force counter to 0 on the next edge (beats en)
//   en     in   advance the counter on this edge; when low the count is frozen
//   limit  in   terminal prescale value
//   tick   out  combinational: en && count == limit
// -----------------------------------------------------------------------------
module timer_ctrl_prescaler #(
  parameter int PRE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [PRE_WIDTH-1:0] limit,
  output logic                 tick
);

  logic [PRE_WIDTH-1:0] pre_cnt_q;
  logic [PRE_WIDTH-1:0] pre_cnt_d;
  logic                 tick_d;

  always_comb begin
    tick_d    = en && (pre_cnt_q == limit);
    pre_cnt_d = pre_cnt_q;
    if (clr) begin
      pre_cnt_d = '0;
    end else if (en) begin
      pre_cnt_d = tick_d ? '0 : pre_cnt_q + PRE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

  assign tick = tick_d;

endmodule

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
// Run controller for a WIDTH-bit tick counter. A start in IDLE snapshots the
// mode / prescale / compare inputs into shadow registers and begins a run.
// The main count advances once per prescale+1 clocks; reaching compare gives
// a terminal tick (match pulse), after which the count wraps (periodic) or
// the run ends with a done pulse (one-shot). pause freezes the run, stop
// aborts it.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   pulse, begins a run (IDLE only)
//   stop      in   pulse, aborts a run / blocks a simultaneous start
//   pause     in   level, freezes counting while high during a run
//   mode      in   0 one-shot, 1 periodic (sampled on start)
//   prescale  in   main count advances every prescale+1 clocks (sampled on start)
//   compare   in   terminal count (sampled on start)
//   cnt       out  current main count
//   busy      out  state is RUN or PAUSE
//   paused    out  state is PAUSE
//   match     out  one-cycle pulse per terminal tick
//   done      out  one-cycle pulse when a one-shot run completes
// -----------------------------------------------------------------------------
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int PRE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pause,
  input  logic                 mode,
  input  logic [PRE_WIDTH-1:0] prescale,
  input  logic [WIDTH-1:0]     compare,
  output logic [WIDTH-1:0]     cnt,
  output logic                 busy,
  output logic                 paused,
  output logic                 match,
  output logic                 done
);

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [PRE_WIDTH-1:0] prescale_q, prescale_d;
  logic [WIDTH-1:0]     compare_q, compare_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 paused_q, paused_d;
  logic                 match_q, match_d;
  logic                 done_q, done_d;

  logic launch;    // accepted start from IDLE
  logic abort;     // stop during a run
  logic active;    // counters advance on this edge
  logic tick;      // prescaler wrap on this edge
  logic terminal;  // tick that lands on compare_q

  // Counting happens on any run-phase edge that is neither stopped nor
  // paused. This includes the PAUSE->RUN release edge, so a pause held for
  // N clocks delays the run by exactly N clocks.
  always_comb begin
    launch   = (state_q == ST_IDLE) && start && !stop;
    abort    = in_run_phase(state_q) && stop;
    active   = in_run_phase(state_q) && !stop && !pause;
    terminal = tick && (cnt_q == compare_q);
  end

  timer_ctrl_prescaler #(
    .PRE_WIDTH (PRE_WIDTH)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clr   (launch || abort),
    .en    (active),
    .limit (prescale_q),
    .tick  (tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: stop > pause > tick
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (terminal && (mode_q == MODE_ONESHOT)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow configuration and main count
  always_comb begin
    mode_d     = mode_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    cnt_d      = cnt_q;
    if (launch) begin
      mode_d     = mode;
      prescale_d = prescale;
      compare_d  = compare;
      cnt_d      = '0;
    end else if (abort) begin
      cnt_d = '0;
    end else if (tick) begin
      if (terminal) begin
        // One-shot parks on the terminal value; periodic wraps.
        cnt_d = (mode_q == MODE_PERIODIC) ? '0 : cnt_q;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  // Registered outputs, decoded from the next state so they line up with it
  always_comb begin
    busy_d   = in_run_phase(state_d);
    paused_d = (state_d == ST_PAUSE);
    match_d  = terminal;
    done_d   = terminal && (mode_q == MODE_ONESHOT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_ONESHOT;
      prescale_q <= '0;
      compare_q  <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      paused_q   <= 1'b0;
      match_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      prescale_q <= prescale_d;
      compare_q  <= compare_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      paused_q   <= paused_d;
      match_q    <= match_d;
      done_q     <= done_d;
    end
  end

  assign cnt    = cnt_q;
  assign busy   = busy_q;
  assign paused = paused_q;
  assign match  = match_q;
  assign done   = done_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl
// Directed scenarios followed by randomized traffic. Every clock edge is
// mirrored by a reference model that tracks the number of active clocks in
// the current run and derives cnt / match / done from the period arithmetic:
//   ticks      = n / (P+1)
//   cnt        = ticks mod (C+1)
//   terminal   when n is a multiple of (C+1)*(P+1)
// -----------------------------------------------------------------------------
module tb_timer_ctrl;

  localparam int WIDTH     = 16;
  localparam int PRE_WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 rst, start, stop, pause, mode;
  logic [PRE_WIDTH-1:0] prescale;
  logic [WIDTH-1:0]     compare;
  logic [WIDTH-1:0]     cnt;
  logic                 busy, paused, match, done;

  always #5 clk = ~clk;

  timer_ctrl #(
    .WIDTH     (WIDTH),
    .PRE_WIDTH (PRE_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .prescale (prescale),
    .compare  (compare),
    .cnt      (cnt),
    .busy     (busy),
    .paused   (paused),
    .match    (match),
    .done     (done)
  );

  int     n_vec = 0;
  int     n_err = 0;
  longint cyc   = 0;

  // Reference model state
  bit     m_busy, m_paused, m_match, m_done, m_mode;
  longint m_cnt, m_n, m_pre, m_cmp;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    longint per;
    m_match = 1'b0;
    m_done  = 1'b0;
    if (rst) begin
      m_busy = 0; m_paused = 0; m_cnt = 0; m_n = 0;
      m_mode = 0; m_pre = 0; m_cmp = 0;
    end else if (!m_busy) begin
      if (start && !stop) begin
        m_mode = mode;
        m_pre  = longint'(prescale);
        m_cmp  = longint'(compare);
        m_n    = 0;
        m_cnt  = 0;
        m_busy = 1;
        m_paused = 0;
      end
    end else if (stop) begin
      m_busy = 0; m_paused = 0; m_cnt = 0;
    end else if (pause) begin
      m_paused = 1;
    end else begin
      m_paused = 0;
      m_n++;
      per = (m_cmp + 1) * (m_pre + 1);
      if (m_n % per == 0) begin
        m_match = 1;
        if (!m_mode) begin
          m_done = 1;
          m_busy = 0;
          m_cnt  = m_cmp;
        end else begin
          m_cnt = 0;
        end
      end else begin
        m_cnt = (m_n / (m_pre + 1)) % (m_cmp + 1);
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    chk_val("cnt",    64'(cnt),    64'(m_cnt));
    chk_val("busy",   64'(busy),   64'(m_busy));
    chk_val("paused", 64'(paused), 64'(m_paused));
    chk_val("match",  64'(match),  64'(m_match));
    chk_val("done",   64'(done),   64'(m_done));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic configure(input logic md, input int pre, input int cmp);
    mode     = md;
    prescale = PRE_WIDTH'(pre);
    compare  = WIDTH'(cmp);
  endtask

  // Steps until match is seen; returns the cycle stamp, -1 on timeout.
  task automatic wait_match(input int limit, output longint at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (match === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk_val("match_timeout", 0, 1);
  endtask

  initial begin
    longint t0, t1, t2;
    int     hits;

    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    configure(1'b0, 0, 0);
    run(2);
    chk_val("rst_cnt",  64'(cnt),  0);
    chk_val("rst_busy", 64'(busy), 0);
    rst = 1'b0;
    run(2);

    // Periodic, prescale 0, compare 3: match every 4th clock, never done
    configure(1'b1, 0, 3);
    pulse_start();
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (match) hits++;
      if (done) hits += 100;
    end
    chk_val("p3_matches", 64'(hits), 3);
    chk_val("p3_busy", 64'(busy), 1);
    pulse_stop();

    // One-shot, prescale 1, compare 5: match+done 12 clocks after start
    configure(1'b0, 1, 5);
    pulse_start();
    t0 = cyc;
    wait_match(40, t1);
    chk_val("os_latency", 64'(t1 - t0), 12);
    chk_val("os_done", 64'(done), 1);
    chk_val("os_cnt",  64'(cnt),  5);
    chk_val("os_busy", 64'(busy), 0);
    run(3);
    chk_val("os_hold", 64'(cnt), 5);
    pulse_start();
    chk_val("os_restart", 64'(cnt), 0);
    t0 = cyc;
    wait_match(40, t1);
    chk_val("os_latency2", 64'(t1 - t0), 12);
    run(2);

    // 40 kHz -> 1 Hz: prescale 39999, compare 0
    configure(1'b1, 39999, 0);
    pulse_start();
    t0 = cyc;
    wait_match(41000, t1);
    chk_val("hz_first", 64'(t1 - t0), 40000);
    pulse_stop();

    // Three consecutive periodic intervals, prescale 999, compare 0
    configure(1'b1, 999, 0);
    pulse_start();
    t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      wait_match(1100, t1);
      chk_val("hz_interval", 64'(t1 - t0), 1000);
      t0 = t1;
    end
    pulse_stop();

    // Pause for 7 clocks at cnt = 4 delays the terminal match by 7
    configure(1'b1, 0, 9);
    pulse_start();
    t0 = cyc;
    run(4);
    chk_val("pz_cnt_before", 64'(cnt), 4);
    pause = 1'b1;
    run(7);
    chk_val("pz_paused", 64'(paused), 1);
    chk_val("pz_frozen", 64'(cnt), 4);
    pause = 1'b0;
    wait_match(40, t1);
    chk_val("pz_latency", 64'(t1 - t0), 17);
    pulse_stop();

    // Stop at cnt = 6
    configure(1'b1, 0, 9);
    pulse_start();
    run(6);
    chk_val("st_cnt_before", 64'(cnt), 6);
    pulse_stop();
    chk_val("st_busy",  64'(busy),  0);
    chk_val("st_cnt",   64'(cnt),   0);
    chk_val("st_match", 64'(match), 0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk_val("ss_busy", 64'(busy), 0);

    // start during a run with a new compare is ignored
    configure(1'b1, 0, 3);
    pulse_start();
    t0 = cyc;
    run(2);
    compare = WIDTH'(7);
    pulse_start();
    wait_match(20, t1);
    chk_val("rs_first", 64'(t1 - t0), 4);
    wait_match(20, t2);
    chk_val("rs_period", 64'(t2 - t1), 4);
    pulse_stop();

    // Reset in the middle of a one-shot
    configure(1'b0, 0, 9);
    pulse_start();
    run(3);
    chk_val("rr_cnt_before", 64'(cnt), 3);
    rst = 1'b1; step(); rst = 1'b0;
    chk_val("rr_busy", 64'(busy), 0);
    chk_val("rr_cnt",  64'(cnt),  0);
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done || match || busy) hits++;
    end
    chk_val("rr_quiet", 64'(hits), 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      mode     = 1'($urandom_range(0, 1));
      prescale = PRE_WIDTH'($urandom_range(0, 3));
      compare  = ($urandom_range(0, 19) == 0) ? '1 : WIDTH'($urandom_range(0, 7));
      step();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
